// File: rtl/uart_cmd_controller.sv
// UART command controller: turns 5-byte frames (SYNC, ADDR, DATA_H, DATA_L, CHK)
// from the asynchronous receiver into register write strobes, answers each
// frame with ACK/NAK through the transmitter handshake, and abandons frames
// whose bytes stop arriving.
module uart_cmd_controller #(
    parameter int         TIMEOUT_CYCLES = 24000,
    parameter logic [7:0] SYNC_BYTE      = 8'hA5,
    parameter logic [7:0] ACK_BYTE       = 8'h06,
    parameter logic [7:0] NAK_BYTE       = 8'h15
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rx_ready,
    input  logic [7:0]  rx_data,
    input  logic        tx_busy,
    output logic        tx_start,
    output logic [7:0]  tx_data,
    output logic        wr_en,
    output logic [7:0]  wr_addr,
    output logic [15:0] wr_data,
    output logic        busy,
    output logic        err_chk,
    output logic        err_timeout,
    output logic        err_overrun
);

    localparam int                CNT_W   = $clog2(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(TIMEOUT_CYCLES - 1);

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_ADDR   = 3'd1;
    localparam logic [2:0] ST_DATA_H = 3'd2;
    localparam logic [2:0] ST_DATA_L = 3'd3;
    localparam logic [2:0] ST_CHK    = 3'd4;
    localparam logic [2:0] ST_COMMIT = 3'd5;
    localparam logic [2:0] ST_RESP   = 3'd6;

    logic [2:0]       state;
    logic             rx_meta;
    logic             rx_sync;
    logic             rx_prev;
    logic             byte_evt;
    logic [7:0]       addr_q;
    logic [7:0]       data_h_q;
    logic [7:0]       data_l_q;
    logic [CNT_W-1:0] tmo_cnt;
    logic             in_frame;

    assign in_frame = (state == ST_ADDR) || (state == ST_DATA_H) ||
                      (state == ST_DATA_L) || (state == ST_CHK);

    // Bring rx_ready into the clk domain and turn its rising edge into a single-cycle byte event.
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_meta  <= 1'b0;
            rx_sync  <= 1'b0;
            rx_prev  <= 1'b0;
            byte_evt <= 1'b0;
        end else begin
            rx_meta  <= rx_ready;
            rx_sync  <= rx_meta;
            rx_prev  <= rx_sync;
            byte_evt <= rx_sync & ~rx_prev;
        end
    end

    // Frame parser, inter-byte timeout supervisor and registered output strobes.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ST_IDLE;
            tmo_cnt     <= '0;
            addr_q      <= 8'h00;
            data_h_q    <= 8'h00;
            data_l_q    <= 8'h00;
            wr_en       <= 1'b0;
            wr_addr     <= 8'h00;
            wr_data     <= 16'h0000;
            tx_data     <= 8'h00;
            err_chk     <= 1'b0;
            err_timeout <= 1'b0;
        end else begin
            wr_en       <= 1'b0;
            err_chk     <= 1'b0;
            err_timeout <= 1'b0;

            if (in_frame) begin
                if (byte_evt) begin
                    tmo_cnt <= '0;
                end else if (tmo_cnt == CNT_MAX) begin
                    tmo_cnt     <= '0;
                    err_timeout <= 1'b1;
                    state       <= ST_IDLE;
                end else begin
                    tmo_cnt <= tmo_cnt + 1'b1;
                end
            end else begin
                tmo_cnt <= '0;
            end

            case (state)
                ST_IDLE: begin
                    if (byte_evt && (rx_data == SYNC_BYTE)) begin
                        state <= ST_ADDR;
                    end
                end
                ST_ADDR: begin
                    if (byte_evt) begin
                        addr_q <= rx_data;
                        state  <= ST_DATA_H;
                    end
                end
                ST_DATA_H: begin
                    if (byte_evt) begin
                        data_h_q <= rx_data;
                        state    <= ST_DATA_L;
                    end
                end
                ST_DATA_L: begin
                    if (byte_evt) begin
                        data_l_q <= rx_data;
                        state    <= ST_CHK;
                    end
                end
                ST_CHK: begin
                    if (byte_evt) begin
                        if (rx_data == (addr_q ^ data_h_q ^ data_l_q)) begin
                            wr_en   <= 1'b1;
                            wr_addr <= addr_q;
                            wr_data <= {data_h_q, data_l_q};
                            state   <= ST_COMMIT;
                        end else begin
                            err_chk <= 1'b1;
                            tx_data <= NAK_BYTE;
                            state   <= ST_RESP;
                        end
                    end
                end
                ST_COMMIT: begin
                    tx_data <= ACK_BYTE;
                    state   <= ST_RESP;
                end
                ST_RESP: begin
                    if (!tx_busy) begin
                        state <= ST_IDLE;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    // The response leaves in the first RESP cycle the transmitter is free; bytes
    // arriving while a frame is being committed or answered are dropped and flagged.
    always_comb begin
        tx_start    = (state == ST_RESP) && !tx_busy;
        busy        = (state != ST_IDLE);
        err_overrun = byte_evt && ((state == ST_COMMIT) || (state == ST_RESP));
    end

endmodule
